sd_access_arbiter: RTL and testbench
====================================

// Module: sd_access_arbiter
// PURPOSE
//   Round-robin arbiter that shares the single SD card interface between the
//   six audio channel readers. Drives the per-channel grant vector, holds a
//   grant until the owner drops its request, and inserts a one-cycle turnaround
//   between owners. A watchdog revokes a hung grant and logs a sticky per-channel
//   fault for the status LEDs.
// PARAMETERS
//   N          6       number of requesters
//   IDX_W      3       width of owner index; 2**IDX_W >= N
//   TIMEOUT_W  20      width of watchdog counter
//   TIMEOUT    1000000 max grant length in Clk cycles; 0 disables the watchdog
// PORTS
//   Clk            in   1      system clock (SD interface clock domain)
//   nReset         in   1      asynchronous reset, active low
//   Request        in   N      per-channel request, level; held until transfer done
//   Busy           in   1      SD interface busy; new grants are blocked while high
//   Timeout_Clear  in   1      one-cycle pulse; clears all Timeout_Flag bits
//   Grant          out  N      one-hot or zero grant, registered
//   Owner          out  IDX_W  index of current owner; valid only when Owner_Valid
//   Owner_Valid    out  1      high while any Grant bit is high
//   Timeout_Flag   out  N      sticky; bit i set when channel i's grant was revoked
// BEHAVIOUR
//   Reset (async, nReset low): state IDLE; Grant=0, Owner=0, Owner_Valid=0,
//     Timeout_Flag=0, Pointer=0, Mask=0, watchdog counter=0.
//   Eligible = Request & ~Mask. All outputs are registered.
//   IDLE: if |Eligible && !Busy -> pick the first eligible index at or after
//     Pointer, wrapping N-1 -> 0. Next edge: Grant[idx]=1, Owner=idx,
//     Owner_Valid=1, counter=0, go GRANT. Latency is 1 cycle from request to grant.
//     If Busy is high, stay in IDLE and grant nothing.
//   GRANT: Busy is ignored. Counter increments and saturates at all-ones.
//     - Request[Owner] low -> next edge Grant=0, Owner_Valid=0,
//       Pointer=(Owner+1) mod N, go RELEASE.
//     - TIMEOUT!=0 and counter==TIMEOUT-1 with Request[Owner] still high ->
//       next edge revoke as above, Timeout_Flag[Owner]=1, Mask[Owner]=1.
//     - Requests from other channels have no effect on the current grant.
//   RELEASE: exactly one cycle with Grant=0, then go IDLE. A new grant is
//     therefore visible at least 2 cycles after the previous grant falls.
//   Mask[i] clears on any edge where Request[i] is low. A timed-out channel must
//     deassert its request before it can win again.
//   Timeout_Clear: clears all flags. If a set and a clear hit the same bit on the
//     same edge, the set wins.
//   Owner holds its last value while Owner_Valid=0.
//   Grant never has more than one bit set. Indices >= N are never granted.
//   Pointer wraps from N-1 to 0.
//   Request bits may drop before their grant is issued; no grant is issued to a
//     channel whose Request is low at the arbitration edge.
// TESTING
//   1 Reset, Request=6'b000001, Busy=0 -> Grant=000001 on the next edge;
//     drop Request -> Grant=0 next edge; RELEASE lasts 1 cycle.
//   2 Request=6'b111111 held, each owner drops its request for 1 cycle after 4
//     grant cycles, then re-asserts -> grant order 0,1,2,3,4,5,0.
//   3 Pointer=5 (after ch4 served), Request=6'b100001 -> ch5 granted, then ch0
//     (wrap).
//   4 Busy=1 with Request=6'b000100 for 10 cycles -> Grant=0 throughout;
//     Busy=0 -> Grant=000100 on the next edge. Raise Busy mid-grant -> grant
//     holds.
//   5 TIMEOUT=16, ch2 holds Request -> Grant[2] falls 16 cycles after rising,
//     Timeout_Flag=000100; ch2 not regranted until Request[2] toggles low;
//     pulse Timeout_Clear -> flags=0.
//   6 Assert nReset low during GRANT of ch3 -> Grant=0, flags=0 immediately;
//     after release ch0 wins first.

Source files
------------

// File: rtl/sd_access_arbiter.sv
// -----------------------------------------------------------------------------
// sd_access_arbiter
//   Round-robin arbiter sharing the single SD card interface between the audio
//   channel readers. A grant is held until its owner drops the request, and
//   every hand-over passes through a one-cycle turnaround with no grant. A
//   watchdog revokes a grant that stays up too long, masks that channel until
//   it lets go of its request, and records a sticky per-channel fault flag.
//
// Handshake (request/grant): Request[i] is a level raised by channel i and
//   held for the whole transfer. The arbiter answers with Grant[i] one cycle
//   after an arbitration edge. The transfer ends on the edge where the owner
//   sees its own Request[i] low; Grant drops on that edge. A request that
//   disappears before arbitration is simply never granted.
//
// Ports
//   Clk            system clock (SD interface clock domain)
//   nReset         asynchronous reset, active low
//   Request[N]     per-channel request level
//   Busy           SD interface busy; blocks new grants (not held ones)
//   Timeout_Clear  one-cycle pulse clearing all Timeout_Flag bits
//   Grant[N]       registered one-hot-or-zero grant
//   Owner          index of the current/last owner
//   Owner_Valid    high while any Grant bit is high
//   Timeout_Flag   sticky per-channel watchdog fault flags
//   Debug_State    current arbiter state (0 idle, 1 grant, 2 release)
// -----------------------------------------------------------------------------
module sd_access_arbiter #(
  parameter int N         = 6,
  parameter int IDX_W     = 3,
  parameter int TIMEOUT_W = 20,
  parameter int TIMEOUT   = 1000000
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic [N-1:0]     Request,
  input  logic             Busy,
  input  logic             Timeout_Clear,
  output logic [N-1:0]     Grant,
  output logic [IDX_W-1:0] Owner,
  output logic             Owner_Valid,
  output logic [N-1:0]     Timeout_Flag,
  output logic [1:0]       Debug_State
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam bit                   WD_EN   = (TIMEOUT != 0);
  // Revoke on the edge where the counter has already counted TIMEOUT-1 held
  // cycles, so the grant is visible for exactly TIMEOUT cycles.
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N - 1);

  state_t               state, state_n;
  logic [N-1:0]         grant_n;
  logic [IDX_W-1:0]     owner_n;
  logic                 owner_valid_n;
  logic [N-1:0]         flag_n;
  logic [IDX_W-1:0]     pointer, pointer_n;
  logic [N-1:0]         mask, mask_n;
  logic [TIMEOUT_W-1:0] count, count_n;

  logic [N-1:0]         eligible;
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic [N-1:0]         owner_onehot;
  logic [N-1:0]         flag_set;
  logic [IDX_W-1:0]     pointer_after_owner;

  assign eligible            = Request & ~mask;
  assign owner_onehot        = N'(1) << Owner;
  assign pointer_after_owner = (Owner == LAST_IDX) ? '0 : Owner + IDX_W'(1);
  assign Debug_State         = state;

  // First eligible channel at or after the pointer, wrapping N-1 -> 0.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 0; k < N; k++) begin
      cand = int'(pointer) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IDX_W'(cand);
      if (!pick_found && eligible[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_n       = state;
    grant_n       = Grant;
    owner_n       = Owner;
    owner_valid_n = Owner_Valid;
    pointer_n     = pointer;
    count_n       = count;
    flag_set      = '0;

    unique case (state)
      ST_IDLE: begin
        if (pick_found && !Busy) begin
          grant_n       = N'(1) << pick_idx;
          owner_n       = pick_idx;
          owner_valid_n = 1'b1;
          count_n       = '0;
          state_n       = ST_GRANT;
        end
      end
      ST_GRANT: begin
        count_n = (count == '1) ? count : count + TIMEOUT_W'(1);
        if (!Request[Owner]) begin
          grant_n       = '0;
          owner_valid_n = 1'b0;
          pointer_n     = pointer_after_owner;
          state_n       = ST_RELEASE;
        end else if (WD_EN && count == TO_LAST) begin
          grant_n       = '0;
          owner_valid_n = 1'b0;
          pointer_n     = pointer_after_owner;
          flag_set      = owner_onehot;
          state_n       = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n       = ST_IDLE;
        grant_n       = '0;
        owner_valid_n = 1'b0;
      end
    endcase

    // A mask bit lives only while its request stays high; a fresh watchdog
    // revoke re-arms it (the owner's request is high in that case).
    mask_n = (mask & Request) | flag_set;
    // Set beats clear when both hit the same bit on one edge.
    flag_n = (Timeout_Flag & ~{N{Timeout_Clear}}) | flag_set;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state        <= ST_IDLE;
      Grant        <= '0;
      Owner        <= '0;
      Owner_Valid  <= 1'b0;
      Timeout_Flag <= '0;
      pointer      <= '0;
      mask         <= '0;
      count        <= '0;
    end else begin
      state        <= state_n;
      Grant        <= grant_n;
      Owner        <= owner_n;
      Owner_Valid  <= owner_valid_n;
      Timeout_Flag <= flag_n;
      pointer      <= pointer_n;
      mask         <= mask_n;
      count        <= count_n;
    end
  end

endmodule

// File: tb/tb_sd_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sd_access_arbiter
//   Self-checking bench for sd_access_arbiter (watchdog shortened to 16).
//   A behavioural model tracks who owns the interface, how long it has held
//   it, the round-robin start point, masked channels and sticky flags, and
//   is stepped on every rising edge with the same inputs the DUT sees.
// -----------------------------------------------------------------------------
module tb_sd_access_arbiter;

  localparam int N     = 6;
  localparam int IDX_W = 3;
  localparam int TW    = 20;
  localparam int TO    = 16;

  // ---------------- clock / reset ----------------
  logic             Clk = 1'b0;
  logic             nReset = 1'b0;
  logic [N-1:0]     req = '0;
  logic             busy = 1'b0;
  logic             clr = 1'b0;
  logic [N-1:0]     Grant;
  logic [IDX_W-1:0] Owner;
  logic             Owner_Valid;
  logic [N-1:0]     Timeout_Flag;
  logic [1:0]       Debug_State;

  always #5 Clk = ~Clk;

  sd_access_arbiter #(
    .N(N), .IDX_W(IDX_W), .TIMEOUT_W(TW), .TIMEOUT(TO)
  ) dut (
    .Clk(Clk), .nReset(nReset), .Request(req), .Busy(busy),
    .Timeout_Clear(clr), .Grant(Grant), .Owner(Owner),
    .Owner_Valid(Owner_Valid), .Timeout_Flag(Timeout_Flag),
    .Debug_State(Debug_State)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [IDX_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  int           m_owner;   // -1 when nobody holds the interface
  int           m_age;     // edges since the current grant rose
  bit           m_gap;     // turnaround cycle pending
  int           m_ptr;
  int           m_last;    // last granted index (Owner output)
  bit           m_new;     // a grant was issued on the latest edge
  logic [N-1:0] m_mask;
  logic [N-1:0] m_flag;

  function automatic void model_reset();
    m_owner = -1; m_age = 0; m_gap = 0; m_ptr = 0; m_last = 0;
    m_new = 0; m_mask = '0; m_flag = '0;
  endfunction

  function automatic void model_step(input logic [N-1:0] r, input logic b, input logic c);
    logic [N-1:0] set_v;
    set_v = '0;
    m_new = 0;
    if (m_owner >= 0) begin
      m_age++;
      if (!r[m_owner] || m_age == TO) begin
        if (r[m_owner]) set_v[m_owner] = 1'b1;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_gap   = 1;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (!b) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (m_owner < 0 && r[i] && !m_mask[i]) begin
          m_owner = i; m_age = 0; m_last = i; m_new = 1;
        end
      end
    end
    m_mask = (m_mask & r) | set_v;
    m_flag = (m_flag & ~{N{c}}) | set_v;
  endfunction

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  // ---------------- driver tasks ----------------
  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge Clk);
    model_step(req, busy, clr);
    @(negedge Clk);
    check("grant", 32'(Grant), 32'(model_grant()));
    check("owner_valid", 32'(Owner_Valid), 32'(m_owner >= 0));
    check("owner", 32'(Owner), 32'(m_last));
    check("flags", 32'(Timeout_Flag), 32'(m_flag));
    if (m_new && exp_q.size() > 0) check("order", 32'(Owner), 32'(exp_q.pop_front()));
  endtask

  task automatic do_reset();
    @(negedge Clk);
    nReset = 1'b0;
    req = '0; busy = 1'b0; clr = 1'b0;
    model_reset();
    #1;
    check("reset_grant", 32'(Grant), 32'd0);
    check("reset_flags", 32'(Timeout_Flag), 32'd0);
    @(negedge Clk);
    nReset = 1'b1;
  endtask

  task automatic idle_for(input int n);
    req = '0; busy = 1'b0; clr = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  // Hold base requests; the current owner drops its bit for one cycle once it
  // has seen `hold` grant cycles. Stops when the expected order is consumed.
  task automatic serve(input logic [N-1:0] base, input int hold, input int budget);
    int cyc;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < budget) begin
      req = base;
      if (m_owner >= 0 && m_age == hold - 1) req[m_owner] = 1'b0;
      tick();
      cyc++;
    end
    check("serve_done", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  initial begin
    int n;
    model_reset();
    do_reset();
    check("reset_owner", 32'(Owner), 32'd0);
    check("reset_valid", 32'(Owner_Valid), 32'd0);

    // 1: single request, one-cycle latency, release gap
    req = 6'b000001; tick();
    check("t1_grant", 32'(Grant), 32'h01);
    req = '0; tick();
    check("t1_drop", 32'(Grant), 32'h00);
    req = 6'b000001; tick();
    check("t1_release_gap", 32'(Grant), 32'h00);
    tick();
    check("t1_regrant", 32'(Grant), 32'h01);
    idle_for(3);

    // 2: all request, full rotation 0..5,0
    do_reset();
    exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    serve(6'b111111, 4, 200);
    idle_for(3);

    // 3: pointer at 5 after ch4 served, then wrap to 0
    do_reset();
    exp_q = '{3'd4};
    serve(6'b010000, 2, 50);
    idle_for(3);
    exp_q = '{3'd5, 3'd0};
    serve(6'b100001, 3, 100);
    idle_for(3);

    // 4: Busy blocks new grants but not held ones
    busy = 1'b1; req = 6'b000100;
    for (int k = 0; k < 10; k++) tick();
    check("t4_busy_block", 32'(Grant), 32'h00);
    busy = 1'b0; tick();
    check("t4_grant", 32'(Grant), 32'h04);
    busy = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("t4_hold", 32'(Grant), 32'h04);
    idle_for(3);

    // 5: watchdog on ch2
    req = 6'b000100; tick();
    n = 0;
    while (Grant[2] && n < 100) begin n++; tick(); end
    check("t5_grant_len", 32'(n), 32'(TO));
    check("t5_flag", 32'(Timeout_Flag), 32'h04);
    for (int k = 0; k < 10; k++) tick();
    check("t5_masked", 32'(Grant), 32'h00);
    req = '0; tick();
    req = 6'b000100; tick();
    check("t5_regrant", 32'(Grant), 32'h04);
    idle_for(3);
    clr = 1'b1; tick(); clr = 1'b0;
    check("t5_clear", 32'(Timeout_Flag), 32'h00);
    // clear pulse landing on the revoke edge: set wins
    req = 6'b000010; tick();
    n = 0;
    while (m_age < TO - 1 && n < 100) begin n++; tick(); end
    clr = 1'b1; tick(); clr = 1'b0;
    check("t5_set_wins", 32'(Timeout_Flag), 32'h02);
    check("t5_revoked", 32'(Grant), 32'h00);
    req = '0; tick(); tick();

    // 6: async reset during ch3 grant
    req = 6'b001000; tick(); tick();
    check("t6_pre", 32'(Grant), 32'h08);
    #2 nReset = 1'b0;
    #1;
    check("t6_async_grant", 32'(Grant), 32'h00);
    check("t6_async_flags", 32'(Timeout_Flag), 32'h00);
    model_reset();
    req = 6'b001001;
    @(negedge Clk);
    nReset = 1'b1;
    tick();
    check("t6_ch0_first", 32'(Grant), 32'h01);
    idle_for(3);

    // random traffic against the model
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_owner == i) begin
          if ($urandom_range(0, 5) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          req[i] = ~req[i];
        end
      end
      busy = ($urandom_range(0, 3) == 0);
      clr  = ($urandom_range(0, 29) == 0);
      tick();
    end
    idle_for(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
